// File: rtl/lector_muestras_if.sv
// Sample-in / tap-out handshake bundle for lector_muestras.
// The master side feeds samples and consumes taps; the slave side is the delay line.
interface lector_muestras_if #(
  parameter int N  = 8,
  parameter int AW = 3
);
  logic [N-1:0]  datain;
  logic          sample_valid;
  logic          sample_ready;
  logic [N-1:0]  tap_data;
  logic [AW-1:0] tap_index;
  logic          tap_valid;
  logic          tap_last;
  logic          tap_ready;
  logic          busy;

  modport master (
    output datain, sample_valid, tap_ready,
    input  sample_ready, tap_data, tap_index, tap_valid, tap_last, busy
  );

  modport slave (
    input  datain, sample_valid, tap_ready,
    output sample_ready, tap_data, tap_index, tap_valid, tap_last, busy
  );
endinterface

// File: rtl/lector_muestras.sv
// Read side of the FIR sample delay line.
// Keeps the last DEPTH samples in a circular register buffer and, after every
// accepted sample, streams all DEPTH taps (newest first) to the serial MAC.
// Optional feature macro: LECTOR_MUESTRAS_OVERRUN_EN adds a sticky overrun_o
// flag raised whenever a sample is offered while the buffer cannot take it.
module lector_muestras #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
`ifdef LECTOR_MUESTRAS_OVERRUN_EN
  output logic               overrun_o,
`endif
  lector_muestras_if.slave   bus_io
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PENULT_IDX = AW'(DEPTH - 2);

  state_t        state_q;
  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] tapIndex_q;
  logic [N-1:0]  tapData_q;
  logic          tapValid_q;
  logic          tapLast_q;
  logic          busy_q;
  logic          accept;
  logic          beat;

  assign bus_io.sample_ready = enable_i & (state_q == IDLE);
  assign accept              = bus_io.sample_valid & bus_io.sample_ready;
  assign beat                = enable_i & tapValid_q & bus_io.tap_ready;

  assign bus_io.tap_data  = tapData_q;
  assign bus_io.tap_index = tapIndex_q;
  assign bus_io.tap_valid = tapValid_q;
  assign bus_io.tap_last  = tapLast_q;
  assign bus_io.busy      = busy_q;

  // Pointer successors: write walks up, read walks back towards older samples.
  always_comb begin
    wrPtr_d = (wrPtr_q == LAST_IDX) ? '0 : wrPtr_q + AW'(1);
    rdPtr_d = (rdPtr_q == '0) ? LAST_IDX : rdPtr_q - AW'(1);
  end

  // Sweep FSM: capture a sample in IDLE, then present one registered tap per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      state_q    <= IDLE;
      tapData_q  <= '0;
      tapIndex_q <= '0;
      tapValid_q <= 1'b0;
      tapLast_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mem_q[wrPtr_q] <= bus_io.datain;
            rdPtr_q        <= wrPtr_q;
            wrPtr_q        <= wrPtr_d;
            tapData_q      <= bus_io.datain;
            tapIndex_q     <= '0;
            tapValid_q     <= 1'b1;
            tapLast_q      <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= READ;
          end
        end
        READ: begin
          if (beat) begin
            rdPtr_q <= rdPtr_d;
            if (tapLast_q) begin
              state_q    <= IDLE;
              tapValid_q <= 1'b0;
              tapLast_q  <= 1'b0;
              busy_q     <= 1'b0;
              tapIndex_q <= '0;
            end else begin
              tapData_q  <= mem_q[rdPtr_d];
              tapIndex_q <= tapIndex_q + AW'(1);
              tapLast_q  <= (tapIndex_q == PENULT_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LECTOR_MUESTRAS_OVERRUN_EN
  // Sticky flag for samples offered while a sweep is running; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else if (bus_io.sample_valid & ~bus_io.sample_ready & enable_i) begin
      overrun_o <= 1'b1;
    end
  end
`endif

endmodule
